// File: rtl/square_root_iter_if.sv
// ----------------------------------------------------------------------------
// square_root_iter_if
// Request/result bundle for square_root_iter.
//   start : request, sampled by the core only while it is idle
//   A     : N-bit unsigned radicand, captured on the accept edge
//   O     : N/2-bit root floor(sqrt(A)), registered
//   R     : N/2+1-bit remainder A - O*O (only when SQRT_REM_EN is defined)
//   busy  : operation in progress
//   ready : result valid, held until the next accepted request
// Modports: master = requester side, slave = square-root core side.
// Optional feature macro: SQRT_REM_EN (adds the R signal).
// ----------------------------------------------------------------------------
interface square_root_iter_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   A;
    logic [N/2-1:0] O;
`ifdef SQRT_REM_EN
    logic [N/2:0]   R;
`endif
    logic           busy;
    logic           ready;

    modport master (
        output start, A,
        input  O, busy, ready
`ifdef SQRT_REM_EN
        , input R
`endif
    );

    modport slave (
        input  start, A,
        output O, busy, ready
`ifdef SQRT_REM_EN
        , output R
`endif
    );
endinterface

// File: rtl/square_root_iter.sv
// ----------------------------------------------------------------------------
// square_root_iter
// Iterative restoring integer square root. Resolves K root bits per clock,
// so a result needs I = (N/2)/K cycles after the accept edge.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : square_root_iter_if.slave (start, A, O, [R], busy, ready)
// Parameters:
//   N : radicand width (even, >= 4)
//   K : root bits per cycle (1 <= K <= N/2, K divides N/2)
// Optional feature macro: SQRT_REM_EN -- when defined the remainder output R
// and its register exist; otherwise they are removed and timing is unchanged.
// ----------------------------------------------------------------------------
module square_root_iter #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic              clk,
    input  logic              rst,
    square_root_iter_if.slave bus
);
    localparam int P  = N / 2;
    localparam int I  = P / K;
    // Remainder path is two bits wider than the root: after j steps the
    // remainder is at most 2*root < 2^(j+1), so shifted-in pairs never spill.
    localparam int RW = P + 2;
    localparam int CW = ($clog2(I + 1) > 1) ? $clog2(I + 1) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  a_p0;
    logic [N-1:0]  a_nxt;
    logic [RW-1:0] rem_p0;
    logic [RW-1:0] rem_nxt;
    logic [P-1:0]  root_p0;
    logic [P-1:0]  root_nxt;
    logic [CW-1:0] cnt_p0;
    logic          last;
    logic [P-1:0]  o_q;
    logic          ready_q;
`ifdef SQRT_REM_EN
    logic [P:0]    r_q;
`endif

    // One restoring digit step. Returns {new remainder, new root}.
    // The trial subtraction is done one bit wider than the operands so its
    // sign tells whether the trial digit 1 fits.
    function automatic logic [RW+P-1:0] digit_step(
        input logic [RW-1:0] rem,
        input logic [P-1:0]  root,
        input logic [1:0]    bits
    );
        logic        [RW+1:0] shifted;
        logic        [RW+1:0] trial;
        logic signed [RW+2:0] t;
        shifted = {rem, bits};
        trial   = {2'b00, root, 2'b01};
        t       = $signed({1'b0, shifted}) - $signed({1'b0, trial});
        if (t >= 0)
            digit_step = {RW'(t), root[P-2:0], 1'b1};
        else
            digit_step = {RW'(shifted), root[P-2:0], 1'b0};
    endfunction

    // K unrolled steps per cycle, consuming radicand pairs from the MSB end.
    always_comb begin : digit_steps
        logic [N-1:0]    a_v;
        logic [RW-1:0]   rem_v;
        logic [P-1:0]    root_v;
        logic [RW+P-1:0] step_v;
        a_v    = a_p0;
        rem_v  = rem_p0;
        root_v = root_p0;
        step_v = '0;
        for (int j = 0; j < K; j++) begin
            step_v = digit_step(rem_v, root_v, a_v[N-1 -: 2]);
            rem_v  = step_v[RW+P-1 -: RW];
            root_v = step_v[P-1:0];
            a_v    = a_v << 2;
        end
        a_nxt    = a_v;
        rem_nxt  = rem_v;
        root_nxt = root_v;
    end

    assign last = (state == CALC) && (cnt_p0 == CW'(I - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = CALC;
            CALC: if (last)      state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: captured radicand, partial root/remainder, iteration count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p0    <= '0;
            rem_p0  <= '0;
            root_p0 <= '0;
            cnt_p0  <= '0;
            o_q     <= '0;
            ready_q <= 1'b0;
`ifdef SQRT_REM_EN
            r_q     <= '0;
`endif
        end else if (state == IDLE) begin
            if (bus.start) begin
                a_p0    <= bus.A;
                rem_p0  <= '0;
                root_p0 <= '0;
                cnt_p0  <= '0;
                ready_q <= 1'b0;
            end
        end else begin
            a_p0    <= a_nxt;
            rem_p0  <= rem_nxt;
            root_p0 <= root_nxt;
            cnt_p0  <= cnt_p0 + 1'b1;
            // ---- result registers: loaded only on the completion edge
            if (last) begin
                o_q     <= root_nxt;
                ready_q <= 1'b1;
`ifdef SQRT_REM_EN
                r_q     <= rem_nxt[P:0];
`endif
            end
        end
    end

    assign bus.O     = o_q;
    assign bus.busy  = (state == CALC);
    assign bus.ready = ready_q;
`ifdef SQRT_REM_EN
    assign bus.R     = r_q;
`endif

endmodule

// File: tb/tb_square_root_iter.sv
// ----------------------------------------------------------------------------
// tb_square_root_iter
// Self-checking bench for square_root_iter. Four instances cover
// (N,K) = (8,1), (8,2), (16,4), (16,8). Expected results are queued when a
// request is driven and popped when the selected instance raises ready.
// Remainder checks are compiled in only when SQRT_REM_EN is defined.
// ----------------------------------------------------------------------------
module tb_square_root_iter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    square_root_iter_if #(.N(8))  if0 ();
    square_root_iter_if #(.N(8))  if1 ();
    square_root_iter_if #(.N(16)) if2 ();
    square_root_iter_if #(.N(16)) if3 ();

    square_root_iter #(.N(8),  .K(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    square_root_iter #(.N(8),  .K(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    square_root_iter #(.N(16), .K(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    square_root_iter #(.N(16), .K(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    typedef struct {
        int     d;
        longint o;
        longint r;
        int     lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          sel      = 0;
    logic        obs_ready;
    logic        obs_busy;
    logic [31:0] obs_o;
    logic [31:0] obs_r;

    always_comb begin
        obs_ready = 1'b0;
        obs_busy  = 1'b0;
        obs_o     = '0;
        obs_r     = '0;
        case (sel)
            0: begin
                obs_ready = if0.ready; obs_busy = if0.busy; obs_o = 32'(if0.O);
`ifdef SQRT_REM_EN
                obs_r = 32'(if0.R);
`endif
            end
            1: begin
                obs_ready = if1.ready; obs_busy = if1.busy; obs_o = 32'(if1.O);
`ifdef SQRT_REM_EN
                obs_r = 32'(if1.R);
`endif
            end
            2: begin
                obs_ready = if2.ready; obs_busy = if2.busy; obs_o = 32'(if2.O);
`ifdef SQRT_REM_EN
                obs_r = 32'(if2.R);
`endif
            end
            default: begin
                obs_ready = if3.ready; obs_busy = if3.busy; obs_o = 32'(if3.O);
`ifdef SQRT_REM_EN
                obs_r = 32'(if3.R);
`endif
            end
        endcase
    end

    function automatic int i_of(input int d);
        case (d)
            0:       return 4;
            1:       return 2;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic longint isqrt(input longint a);
        longint o = 0;
        while ((o + 1) * (o + 1) <= a) o++;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [31:0] a);
        case (d)
            0:       begin if0.start = s; if0.A = a[7:0];  end
            1:       begin if1.start = s; if1.A = a[7:0];  end
            2:       begin if2.start = s; if2.A = a[15:0]; end
            default: begin if3.start = s; if3.A = a[15:0]; end
        endcase
    endtask

    // Called at a falling edge with the instance idle; returns at the falling
    // edge where ready is first seen, so calls can be chained back to back.
    task automatic op(input int d, input logic [31:0] a, input longint eo, input longint er);
        exp_t e;
        int   lat;
        int   bsy;
        sel   = d;
        e.d   = d;
        e.o   = eo;
        e.r   = er;
        e.lat = i_of(d);
        sb.push_back(e);
        drive(d, 1'b1, a);
        @(negedge clk);
        drive(d, 1'b0, ~a);
        check("accept_busy", obs_busy, 1);
        check("accept_ready_low", obs_ready, 0);
        bsy = (obs_busy === 1'b1) ? 1 : 0;
        lat = 0;
        while (obs_ready !== 1'b1 && lat < 4 * e.lat + 4) begin
            @(negedge clk);
            lat++;
            if (obs_busy === 1'b1) bsy++;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("busy_cycles", bsy, e.lat);
        check("ready_done", obs_ready, 1);
        check("root", obs_o, e.o);
`ifdef SQRT_REM_EN
        check("rem", obs_r, e.r);
`endif
    endtask

    initial begin
        longint v;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) drive(d, 1'b0, 32'd0);
        sel = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", obs_busy, 0);
        check("reset_ready", obs_ready, 0);
        check("reset_root", obs_o, 0);
`ifdef SQRT_REM_EN
        check("reset_rem", obs_r, 0);
`endif
        rst = 1'b0;

        op(0, 255, 15, 30);
        op(0, 0, 0, 0);
        op(0, 144, 12, 0);
        op(0, 143, 11, 22);
        repeat (3) @(negedge clk);
        check("ready_held", obs_ready, 1);
        check("root_held", obs_o, 11);

        op(2, 65535, 255, 510);
        op(3, 1000, 31, 39);

        // K=2: start during CALC ignored, start held across completion edge
        sel = 1;
        drive(1, 1'b1, 200);
        @(negedge clk);
        drive(1, 1'b1, 9);
        check("k2_busy_e0", obs_busy, 1);
        @(negedge clk);
        drive(1, 1'b1, 50);
        check("k2_busy_e1", obs_busy, 1);
        check("k2_ready_e1", obs_ready, 0);
        @(negedge clk);
        check("k2_ready_e2", obs_ready, 1);
        check("k2_busy_e2", obs_busy, 0);
        check("k2_root_200", obs_o, 14);
`ifdef SQRT_REM_EN
        check("k2_rem_200", obs_r, 4);
`endif
        @(negedge clk);
        drive(1, 1'b0, 0);
        check("k2_busy_e3", obs_busy, 1);
        check("k2_ready_drop", obs_ready, 0);
        check("k2_root_kept", obs_o, 14);
        @(negedge clk);
        check("k2_ready_e4", obs_ready, 0);
        @(negedge clk);
        check("k2_ready_e5", obs_ready, 1);
        check("k2_root_50", obs_o, 7);
`ifdef SQRT_REM_EN
        check("k2_rem_50", obs_r, 1);
`endif

        // Reset in the middle of a calculation
        op(0, 200, 14, 4);
        drive(0, 1'b1, 100);
        @(negedge clk);
        drive(0, 1'b0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", obs_busy, 0);
        check("rst_mid_ready", obs_ready, 0);
        check("rst_mid_root", obs_o, 0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 49, 7, 0);

        for (int a = 0; a < 256; a++) begin
            v = isqrt(a);
            op(0, a, v, a - v * v);
        end
        for (int n = 0; n < 100; n++) begin
            longint a = longint'($urandom_range(0, 255));
            v = isqrt(a);
            op(1, 32'(a), v, a - v * v);
        end
        for (int n = 0; n < 150; n++) begin
            longint a = longint'($urandom_range(0, 65535));
            v = isqrt(a);
            op(2, 32'(a), v, a - v * v);
        end
        for (int n = 0; n < 50; n++) begin
            longint a = longint'($urandom_range(0, 65535));
            v = isqrt(a);
            op(3, 32'(a), v, a - v * v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/square_root_iter.md
SQUARE_ROOT_ITER -- requirements
Module: square_root_iter

Interface
- REQ-001 The block SHALL have parameter N, default 8, meaning radicand width; even, >= 4.
- REQ-002 The block SHALL have parameter K, default 1, meaning root bits resolved per cycle; 1 <= K <= N/2, and K SHALL divide N/2.
- REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
- REQ-004 Ports SHALL be as follows:
  - clk  input  1  rising-edge clock.
  - rst  input  1  asynchronous active-high reset.
  - start  input  1  request; sampled only when busy=0.
  - A  input  N  unsigned radicand.
  - O  output  N/2  floor(sqrt(A)), registered.
  - R  output  N/2+1  remainder A - O*O, registered; present only with SQRT_REM_EN.
  - busy  output  1  high while an operation is in progress.
  - ready  output  1  result valid, level-held.

Function
- REQ-005 The block SHALL define P = N/2 (root bits) and I = P/K (iterations).
- REQ-006 The state machine SHALL have exactly two states: IDLE and CALC.
- REQ-007 In IDLE with start=1 at a clock edge (the accept edge), the block SHALL:
  - capture A internally;
  - clear the partial root and remainder;
  - clear the iteration counter;
  - set busy=1 and ready=0;
  - go to CALC.
- REQ-008 Input start SHALL be ignored while busy=1; A SHALL be don't-care except at the accept edge.
- REQ-009 Each CALC cycle SHALL perform K unrolled restoring digit steps, MSB pair first. Per step:
  - t = (rem<<2 | next two radicand bits) - (root<<2 | 1);
  - if t >= 0: rem = t, root = root<<1 | 1;
  - else: rem = rem<<2 | bits, root = root<<1.
- REQ-010 Internal remainder arithmetic SHALL be N/2+2 bits wide so that no step overflows.
- REQ-011 At the I-th edge after the accept edge, the block SHALL:
  - load O (and R) with the final values;
  - set ready=1 and busy=0;
  - return to IDLE.
  Latency from accept edge to ready high is exactly I cycles.
- REQ-012 ready, O and R SHALL hold until the next accept edge, where ready SHALL drop to 0; O and R SHALL keep their old values until overwritten at completion.
- REQ-013 A start asserted on the completion edge SHALL be ignored (busy still 1); the same start held one more cycle SHALL be accepted.
- REQ-014 Back-to-back operation SHALL sustain one result per I+1 cycles.
- REQ-015 Results SHALL satisfy O*O <= A < (O+1)*(O+1) and 0 <= R <= 2*O for all A, including A=0 and A=2^N-1.
- REQ-016 The iteration counter SHALL be ceil(log2(I+1)) bits wide, minimum 1, and SHALL never wrap within an operation.

Reset
- REQ-017 On rst=1, immediately and regardless of clk, the block SHALL:
  - force state to IDLE;
  - set O=0, R=0, busy=0, ready=0;
  - clear internal registers and counter.
- REQ-018 Reset asserted mid-CALC SHALL abort the operation with no result; after release the block SHALL accept start at the first clock edge.

Configuration
- REQ-019 The macro SQRT_REM_EN SHALL control the remainder output:
  - defined: port R exists and is loaded at completion;
  - undefined: port R and its output register are absent, and O, busy, ready and timing are unchanged.

Verification
- REQ-020 N=8, K=1: start with A=255 -> ready 4 cycles after accept, O=15, R=30, busy high for exactly 4 cycles.
- REQ-021 N=8, K=1: A=0 -> O=0, R=0; then A=144 -> O=12, R=0; then A=143 -> O=11, R=22.
- REQ-022 N=16, K=4: A=65535 -> O=255, R=510, latency 2 cycles; N=16, K=8, A=1000 -> O=31, R=39, latency 1 cycle.
- REQ-023 N=8, K=2: start with A=200, then pulse start with A=9 during CALC -> O=14, R=4; A=9 never processed; start held on the completion edge is accepted one cycle later.
- REQ-024 N=8, K=1: assert rst mid-CALC (cycle 2) -> busy=0, ready=0, O=0 immediately; start with A=49 after release -> O=7, R=0 after 4 cycles.
- REQ-025 Random: 10k random A per (N,K) in {(8,1),(8,2),(8,4),(16,2),(32,4)}, with and without SQRT_REM_EN -> REQ-015 holds and latency equals I.
